// File: rtl/cache_arb_pkg.sv
// Shared constants for the cache-port arbiters: mode selectors, cache port
// field widths and the requester index width helper.
package cache_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int CACHE_ADDR_W = 32;
  localparam int CACHE_DATA_W = 32;
  localparam int CACHE_REQ_W  = 4;
  localparam int CACHE_SIZE_W = 2;

  // A single requester index still needs one bit so the ports never collapse.
  function automatic int idx_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational rotating-priority picker: first set strobe scanning upward
// from the start pointer (round-robin) or from index 0 (fixed priority).
module cache_arb_pick
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] strobe,
  input  logic [IDX_W-1:0]   start,
  input  logic               rr_mode,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan from the far end back towards the base so the nearest hit wins.
  always_comb begin
    int base;
    int cand;
    base = rr_mode ? int'(start) : 0;
    if (base >= NUM_REQ) base = 0;
    cand = 0;
    idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = base + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (strobe[cand]) idx = IDX_W'(cand);
    end
    any = |strobe;
  end

endmodule

// File: rtl/cache_arbn.sv
// N-way cache port arbiter: fixed or round-robin selection, with the grant
// held across multi-cycle misses until completion or abandonment.
module cache_arbn
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int PASS_IDX = 0,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [CACHE_ADDR_W*NUM_REQ-1:0]  req_address,
  input  logic [NUM_REQ-1:0]               req_strobe,
  input  logic [CACHE_REQ_W*NUM_REQ-1:0]   req_request,
  input  logic [CACHE_SIZE_W*NUM_REQ-1:0]  req_size,
  input  logic [CACHE_DATA_W*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]               req_valid,
  output logic [CACHE_ADDR_W-1:0]          cache_address,
  output logic                             cache_strobe,
  output logic [CACHE_REQ_W-1:0]           cache_request,
  output logic [CACHE_SIZE_W-1:0]          cache_size,
  output logic [CACHE_DATA_W-1:0]          cache_wdata,
  input  logic                             cache_valid,
  output logic [IDX_W-1:0]                 grant_idx,
  output logic                             grant_locked
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] PASS_SEL = IDX_W'(PASS_IDX);
  localparam logic             RR_MODE  = (ARB_MODE == ARB_RR);

  logic             locked;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] sel;
  logic             active;

  logic [CACHE_ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [CACHE_REQ_W-1:0]  req_arr   [NUM_REQ];
  logic [CACHE_SIZE_W-1:0] size_arr  [NUM_REQ];
  logic [CACHE_DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_address[CACHE_ADDR_W*i +: CACHE_ADDR_W];
    assign req_arr[i]   = req_request[CACHE_REQ_W*i +: CACHE_REQ_W];
    assign size_arr[i]  = req_size[CACHE_SIZE_W*i +: CACHE_SIZE_W];
    assign wdata_arr[i] = req_wdata[CACHE_DATA_W*i +: CACHE_DATA_W];
  end

  cache_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .strobe  (req_strobe),
    .start   (rr_ptr),
    .rr_mode (RR_MODE),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  assign sel          = locked ? owner : pick_idx;
  assign active       = locked | pick_any;
  assign grant_locked = locked;

  // Idle parks the address on PASS_IDX so a requester can see its own
  // address reach the cache without a pending request.
  always_comb begin
    req_valid     = '0;
    cache_address = addr_arr[PASS_IDX];
    cache_strobe  = 1'b0;
    cache_request = '0;
    cache_size    = '0;
    cache_wdata   = '0;
    grant_idx     = PASS_SEL;
    if (active) begin
      cache_address  = addr_arr[sel];
      cache_strobe   = req_strobe[sel];
      cache_request  = req_arr[sel];
      cache_size     = size_arr[sel];
      cache_wdata    = wdata_arr[sel];
      grant_idx      = sel;
      req_valid[sel] = req_strobe[sel] & cache_valid;
    end
  end

  // A dropped owner strobe releases the lock without counting as a completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked <= 1'b0;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      if (!locked) begin
        if (cache_strobe && !cache_valid) begin
          locked <= 1'b1;
          owner  <= sel;
        end
      end else if (cache_valid || !req_strobe[owner]) begin
        locked <= 1'b0;
      end
      if (RR_MODE && cache_strobe && cache_valid) begin
        rr_ptr <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_arbn.sv
// Directed bench for cache_arbn: a 3-way fixed-priority instance and a
// 4-way round-robin instance sharing clock and reset.
module tb_cache_arbn;
  import cache_arb_pkg::*;

  logic clk;
  logic reset_n;

  logic [95:0]  f_req_address;
  logic [2:0]   f_req_strobe;
  logic [11:0]  f_req_request;
  logic [5:0]   f_req_size;
  logic [95:0]  f_req_wdata;
  logic [2:0]   f_req_valid;
  logic [31:0]  f_cache_address;
  logic         f_cache_strobe;
  logic [3:0]   f_cache_request;
  logic [1:0]   f_cache_size;
  logic [31:0]  f_cache_wdata;
  logic         f_cache_valid;
  logic [1:0]   f_grant_idx;
  logic         f_grant_locked;

  logic [127:0] r_req_address;
  logic [3:0]   r_req_strobe;
  logic [15:0]  r_req_request;
  logic [7:0]   r_req_size;
  logic [127:0] r_req_wdata;
  logic [3:0]   r_req_valid;
  logic [31:0]  r_cache_address;
  logic         r_cache_strobe;
  logic [3:0]   r_cache_request;
  logic [1:0]   r_cache_size;
  logic [31:0]  r_cache_wdata;
  logic         r_cache_valid;
  logic [1:0]   r_grant_idx;
  logic         r_grant_locked;

  int n_cmp;
  int n_fail;

  cache_arbn #(.NUM_REQ(3), .ARB_MODE(ARB_FIXED), .PASS_IDX(2)) f_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_address   (f_req_address),
    .req_strobe    (f_req_strobe),
    .req_request   (f_req_request),
    .req_size      (f_req_size),
    .req_wdata     (f_req_wdata),
    .req_valid     (f_req_valid),
    .cache_address (f_cache_address),
    .cache_strobe  (f_cache_strobe),
    .cache_request (f_cache_request),
    .cache_size    (f_cache_size),
    .cache_wdata   (f_cache_wdata),
    .cache_valid   (f_cache_valid),
    .grant_idx     (f_grant_idx),
    .grant_locked  (f_grant_locked)
  );

  cache_arbn #(.NUM_REQ(4), .ARB_MODE(ARB_RR), .PASS_IDX(3)) r_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_address   (r_req_address),
    .req_strobe    (r_req_strobe),
    .req_request   (r_req_request),
    .req_size      (r_req_size),
    .req_wdata     (r_req_wdata),
    .req_valid     (r_req_valid),
    .cache_address (r_cache_address),
    .cache_strobe  (r_cache_strobe),
    .cache_request (r_cache_request),
    .cache_size    (r_cache_size),
    .cache_wdata   (r_cache_wdata),
    .cache_valid   (r_cache_valid),
    .grant_idx     (r_grant_idx),
    .grant_locked  (r_grant_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester i: address A000_0000+16i, request i+1, size i, wdata D000_0000+i.
  task automatic applyStimulus();
    for (int i = 0; i < 3; i++) begin
      f_req_address[32*i +: 32] = 32'hA000_0000 + 32'(i * 16);
      f_req_request[4*i +: 4]   = 4'(i + 1);
      f_req_size[2*i +: 2]      = 2'(i);
      f_req_wdata[32*i +: 32]   = 32'hD000_0000 + 32'(i);
    end
    for (int i = 0; i < 4; i++) begin
      r_req_address[32*i +: 32] = 32'hB000_0000 + 32'(i * 16);
      r_req_request[4*i +: 4]   = 4'(i + 1);
      r_req_size[2*i +: 2]      = 2'(i);
      r_req_wdata[32*i +: 32]   = 32'hE000_0000 + 32'(i);
    end
    f_req_strobe  = '0;
    f_cache_valid = 1'b0;
    r_req_strobe  = '0;
    r_cache_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    applyStimulus();
    #1;
    n_cmp++;
    if (f_grant_locked !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_locked: got %b expected 0", f_grant_locked);
    end
    n_cmp++;
    if (f_cache_strobe !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_strobe: got %b expected 0", f_cache_strobe);
    end
    n_cmp++;
    if (f_cache_address !== 32'hA000_0020) begin
      n_fail++; $display("[TB] FAIL reset_pass_addr: got %h expected a0000020", f_cache_address);
    end
    n_cmp++;
    if (f_grant_idx !== 2'd2) begin
      n_fail++; $display("[TB] FAIL reset_grant_idx: got %0d expected 2", f_grant_idx);
    end
    n_cmp++;
    if (r_dut.rr_ptr !== 2'd0) begin
      n_fail++; $display("[TB] FAIL reset_rr_ptr: got %0d expected 0", r_dut.rr_ptr);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fixed_hit();
    @(negedge clk);
    f_req_strobe  = 3'b110;
    f_cache_valid = 1'b1;
    #1;
    n_cmp++;
    if (f_grant_idx !== 2'd1) begin
      n_fail++; $display("[TB] FAIL hit_grant_idx: got %0d expected 1", f_grant_idx);
    end
    n_cmp++;
    if (f_req_valid !== 3'b010) begin
      n_fail++; $display("[TB] FAIL hit_req_valid: got %b expected 010", f_req_valid);
    end
    n_cmp++;
    if (f_cache_address !== 32'hA000_0010) begin
      n_fail++; $display("[TB] FAIL hit_address: got %h expected a0000010", f_cache_address);
    end
    n_cmp++;
    if ({f_cache_request, f_cache_size, f_cache_wdata} !== {4'd2, 2'd1, 32'hD000_0001}) begin
      n_fail++; $display("[TB] FAIL hit_fields: got %h/%h/%h expected 2/1/d0000001",
                         f_cache_request, f_cache_size, f_cache_wdata);
    end
    @(negedge clk);
    f_req_strobe  = 3'b000;
    f_cache_valid = 1'b0;
    #1;
    n_cmp++;
    if (f_grant_locked !== 1'b0) begin
      n_fail++; $display("[TB] FAIL hit_no_lock: got %b expected 0", f_grant_locked);
    end
  endtask

  task automatic test_fixed_miss();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      f_req_strobe  = 3'b101;
      f_cache_valid = (c == 5);
      #1;
      n_cmp++;
      if (f_cache_address !== 32'hA000_0000 || f_grant_idx !== 2'd0) begin
        n_fail++; $display("[TB] FAIL miss_hold_c%0d: got addr %h idx %0d expected a0000000 idx 0",
                           c, f_cache_address, f_grant_idx);
      end
      n_cmp++;
      if (f_grant_locked !== (c > 1)) begin
        n_fail++; $display("[TB] FAIL miss_locked_c%0d: got %b expected %b", c, f_grant_locked, c > 1);
      end
      n_cmp++;
      if (f_req_valid !== ((c == 5) ? 3'b001 : 3'b000)) begin
        n_fail++; $display("[TB] FAIL miss_valid_c%0d: got %b expected %b",
                           c, f_req_valid, (c == 5) ? 3'b001 : 3'b000);
      end
    end
    @(negedge clk);
    f_req_strobe  = 3'b100;
    f_cache_valid = 1'b1;
    #1;
    n_cmp++;
    if (f_grant_locked !== 1'b0 || f_grant_idx !== 2'd2 || f_req_valid !== 3'b100) begin
      n_fail++; $display("[TB] FAIL miss_next_req2: got lock %b idx %0d valid %b expected 0 2 100",
                         f_grant_locked, f_grant_idx, f_req_valid);
    end
    n_cmp++;
    if (f_cache_address !== 32'hA000_0020) begin
      n_fail++; $display("[TB] FAIL miss_next_addr: got %h expected a0000020", f_cache_address);
    end
  endtask

  task automatic test_lock_holds();
    @(negedge clk);
    f_req_strobe  = 3'b100;
    f_cache_valid = 1'b0;
    @(negedge clk);
    f_req_strobe  = 3'b101;
    f_cache_valid = 1'b1;
    #1;
    n_cmp++;
    if (f_grant_idx !== 2'd2 || f_req_valid !== 3'b100) begin
      n_fail++; $display("[TB] FAIL lock_ignores_req0: got idx %0d valid %b expected 2 100",
                         f_grant_idx, f_req_valid);
    end
    @(negedge clk);
    f_req_strobe  = 3'b001;
    #1;
    n_cmp++;
    if (f_grant_idx !== 2'd0 || f_req_valid !== 3'b001 || f_grant_locked !== 1'b0) begin
      n_fail++; $display("[TB] FAIL lock_release_req0: got idx %0d valid %b lock %b expected 0 001 0",
                         f_grant_idx, f_req_valid, f_grant_locked);
    end
    @(negedge clk);
    f_req_strobe  = 3'b000;
    f_cache_valid = 1'b0;
  endtask

  task automatic test_rr_rotation();
    logic [1:0] exp_idx;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      r_req_strobe  = 4'b1111;
      r_cache_valid = 1'b1;
      exp_idx = 2'(c % 4);
      #1;
      n_cmp++;
      if (r_grant_idx !== exp_idx || r_req_valid !== (4'b0001 << exp_idx)) begin
        n_fail++; $display("[TB] FAIL rr_grant_c%0d: got idx %0d valid %b expected %0d %b",
                           c, r_grant_idx, r_req_valid, exp_idx, 4'b0001 << exp_idx);
      end
    end
  endtask

  task automatic test_abandon();
    @(negedge clk);
    r_req_strobe  = 4'b1010;
    r_cache_valid = 1'b0;
    #1;
    n_cmp++;
    if (r_grant_idx !== 2'd1) begin
      n_fail++; $display("[TB] FAIL abandon_first_pick: got %0d expected 1", r_grant_idx);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (r_grant_locked !== 1'b1 || r_dut.owner !== 2'd1) begin
      n_fail++; $display("[TB] FAIL abandon_locked: got lock %b owner %0d expected 1 1",
                         r_grant_locked, r_dut.owner);
    end
    @(negedge clk);
    r_req_strobe = 4'b1000;
    #1;
    n_cmp++;
    if (r_cache_strobe !== 1'b0 || r_grant_idx !== 2'd1) begin
      n_fail++; $display("[TB] FAIL abandon_drop: got strobe %b idx %0d expected 0 1",
                         r_cache_strobe, r_grant_idx);
    end
    @(negedge clk);
    r_cache_valid = 1'b1;
    #1;
    n_cmp++;
    if (r_grant_locked !== 1'b0 || r_dut.rr_ptr !== 2'd1) begin
      n_fail++; $display("[TB] FAIL abandon_release: got lock %b rr_ptr %0d expected 0 1",
                         r_grant_locked, r_dut.rr_ptr);
    end
    n_cmp++;
    if (r_grant_idx !== 2'd3 || r_req_valid !== 4'b1000) begin
      n_fail++; $display("[TB] FAIL abandon_other: got idx %0d valid %b expected 3 1000",
                         r_grant_idx, r_req_valid);
    end
    @(negedge clk);
    r_req_strobe  = 4'b0000;
    r_cache_valid = 1'b0;
    #1;
    n_cmp++;
    if (r_dut.rr_ptr !== 2'd0) begin
      n_fail++; $display("[TB] FAIL rr_wrap: got %0d expected 0", r_dut.rr_ptr);
    end
  endtask

  task automatic test_reset_mid_miss();
    @(negedge clk);
    r_req_strobe  = 4'b0001;
    r_cache_valid = 1'b1;
    @(negedge clk);
    r_req_strobe  = 4'b0100;
    r_cache_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (r_grant_locked !== 1'b1 || r_dut.owner !== 2'd2 || r_dut.rr_ptr !== 2'd1) begin
      n_fail++; $display("[TB] FAIL midreset_pre: got lock %b owner %0d rr %0d expected 1 2 1",
                         r_grant_locked, r_dut.owner, r_dut.rr_ptr);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (r_grant_locked !== 1'b0 || r_dut.owner !== 2'd0 || r_dut.rr_ptr !== 2'd0) begin
      n_fail++; $display("[TB] FAIL midreset_clear: got lock %b owner %0d rr %0d expected 0 0 0",
                         r_grant_locked, r_dut.owner, r_dut.rr_ptr);
    end
    r_req_strobe = 4'b0000;
    #1;
    n_cmp++;
    if (r_cache_strobe !== 1'b0 || r_cache_address !== 32'hB000_0030 || r_grant_idx !== 2'd3) begin
      n_fail++; $display("[TB] FAIL midreset_idle: got strobe %b addr %h idx %0d expected 0 b0000030 3",
                         r_cache_strobe, r_cache_address, r_grant_idx);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      r_req_strobe  = 4'($urandom_range(0, 15));
      r_cache_valid = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (!$onehot0(r_req_valid)) begin
        n_fail++; $display("[TB] FAIL rand_onehot_c%0d: got %b expected at most one bit", c, r_req_valid);
      end
      n_cmp++;
      if ((r_req_valid & ~r_req_strobe) !== 4'b0000) begin
        n_fail++; $display("[TB] FAIL rand_strobe_c%0d: got valid %b strobe %b expected valid within strobe",
                           c, r_req_valid, r_req_strobe);
      end
    end
    @(negedge clk);
    r_req_strobe  = '0;
    r_cache_valid = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_fixed_hit();
    test_fixed_miss();
    test_lock_holds();
    test_rr_rotation();
    test_abandon();
    test_reset_mid_miss();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
